// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle for mem_port_arbiter: request handshake plus read response.
// The requester is the master and the arbiter is the slave; responses are never backpressured.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          valid;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_data
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the memory's second read port and its write port.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN to give requester 0 fixed priority.
module mem_port_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_port_arbiter_if.slave rq0,
  mem_port_arbiter_if.slave rq1,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata
);

  typedef struct packed {
    logic valid;
    logic id;
  } pipe_t;

  pipe_t         pipe [RD_LAT];
  pipe_t         pipe_out;
  logic          grant0;
  logic          grant1;
  logic          accept;
  logic          rd_grant;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [AW-1:0] raddr_q;

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = !reset && rq0.valid;
    grant1 = !reset && rq1.valid && !rq0.valid;
  end
`else
  // rr_last = index of the most recently accepted requester; the other one wins a tie.
  logic rr_last;

  always_comb begin
    grant0 = !reset && rq0.valid && (!rq1.valid ||  rr_last);
    grant1 = !reset && rq1.valid && (!rq0.valid || !rr_last);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)       rr_last <= 1'b1;
    else if (grant0) rr_last <= 1'b0;
    else if (grant1) rr_last <= 1'b1;
  end
`endif

  always_comb begin
    accept    = grant0 | grant1;
    req_we    = grant1 ? rq1.we    : rq0.we;
    req_addr  = grant1 ? rq1.addr  : rq0.addr;
    req_wdata = grant1 ? rq1.wdata : rq0.wdata;
    rd_grant  = accept && !req_we;
    mem_we    = accept &&  req_we;
    mem_waddr = req_addr;
    mem_wdata = req_wdata;
    // Hold the last read address on idle/write cycles so the port does not toggle.
    mem_raddr = rd_grant ? req_addr : raddr_q;
  end

  assign rq0.ready = grant0;
  assign rq1.ready = grant1;

  // NOTE: the tag pipeline is a handful of flops, so it is reset outright; that is what drops in-flight reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      raddr_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      raddr_q <= mem_raddr;
      pipe[0] <= '{valid: rd_grant, id: grant1};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign pipe_out = pipe[RD_LAT-1];

  always_comb begin
    rq0.rsp_valid = pipe_out.valid && !pipe_out.id;
    rq1.rsp_valid = pipe_out.valid &&  pipe_out.id;
    rq0.rsp_data  = rq0.rsp_valid ? mem_rdata : '0;
    rq1.rsp_data  = rq1.rsp_valid ? mem_rdata : '0;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the instruction/data memory's second read port (raddr1/rdata1) and its single write port between two requesters.
- Requester 0 is the CPU load/store stage; requester 1 is the debug/loader engine.
- Grants at most one access per cycle and tracks the memory's fixed 2-cycle read latency.
- Returns each read result to the requester that issued it.

Parameters:
- AW, 16, address width; matches memory raddr/writeAddress.
- DW, 16, data width; matches memory rdata/writeData.
- RD_LAT, 2, memory read latency in cycles from address presented to data valid. The pipeline depth equals RD_LAT.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- rq0_valid  in  1  requester 0 has an access pending.
- rq0_we  in  1  1 = write, 0 = read.
- rq0_addr  in  AW  access address.
- rq0_wdata  in  DW  write data.
- rq0_ready  out  1  requester 0 access accepted this cycle.
- rsp0_valid  out  1  read data for requester 0 valid this cycle.
- rsp0_data  out  DW  read data for requester 0.
- rq1_valid, rq1_we, rq1_addr, rq1_wdata, rq1_ready, rsp1_valid, rsp1_data  same as above, for requester 1.
- mem_raddr  out  AW  to memory raddr1.
- mem_rdata  in  DW  from memory rdata1.
- mem_we  out  1  to memory writeEnable.
- mem_waddr  out  AW  to memory writeAddress.
- mem_wdata  out  DW  to memory writeData.

Behaviour:
- Accept rule: an access is accepted in a cycle where rqN_valid=1 and rqN_ready=1. Requesters hold valid, we, addr and wdata stable until accepted.
- Grant is combinational from the valids and the rr_last register. Exactly one rqN_ready may be high per cycle; rqN_ready=0 whenever rqN_valid=0.
- Arbitration, default round-robin:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not equal to rr_last.
  - rr_last updates to the granted index on every accept.
- Granted write: mem_we=1, mem_waddr=addr, mem_wdata=wdata in the same cycle. The write commits at that clock edge.
- Granted read: mem_raddr=addr in the same cycle. A shift pipeline of RD_LAT stages, each holding {valid, id}, is loaded with {1, N}.
- Read response: when the pipeline output stage has valid=1 and id=N, rspN_valid=1 and rspN_data=mem_rdata.
  - This occurs exactly RD_LAT cycles after the accept cycle; with RD_LAT=2, accept in cycle T gives the response in cycle T+2.
  - At most one rsp valid per cycle. Responses are never backpressured.
- Idle and write cycles: mem_raddr holds its previous value (registered copy) to avoid needless toggling. rspN_data=0 when rspN_valid=0.
- Back-to-back reads: one read per cycle sustained, with no bubbles. Responses return in accept order.
- Read-after-write, same address, write accepted in cycle T:
  - A read accepted in cycle T+1 or later returns the new data.
  - A simultaneous read cannot occur because only one grant per cycle is allowed.
- Reset:
  - While reset=1: rq0_ready=rq1_ready=0, mem_we=0, and all pipeline valids clear at the edge.
  - rr_last resets to 1, so requester 0 wins the first contention.
  - mem_raddr register resets to 0. rsp*_valid=0 and rsp*_data=0 from the first cycle after the reset edge.
  - Reset asserted mid-read: in-flight reads are dropped and no response is issued for them.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: requester 0 always wins contention, and rr_last is neither used nor updated. The loader only proceeds when the CPU is idle.
- Not defined: round-robin as above.

Test Plan:
- Reset, then rq0 read addr 0x0005 (mem[5]=0xBEEF), accepted in cycle T -> rsp0_valid=1 and rsp0_data=0xBEEF in cycle T+2 only; rsp1_valid stays 0.
- rq1 write addr 0x0010 data 0x1234 in cycle T, then rq1 read 0x0010 in cycle T+1 -> mem_we=1 only in cycle T; rsp1_data=0x1234 in cycle T+3.
- Both requesters issue reads every cycle for 6 cycles, first contention after reset -> grants alternate 0,1,0,1,0,1; responses alternate rsp0/rsp1 two cycles later with matching data.
- Same stimulus with MEM_ARB_FIXED_PRIO_EN -> rq0_ready=1 in all 6 cycles and rq1_ready=0; rq1 is accepted in the first cycle rq0_valid drops.
- rq0 reads at cycles T and T+1, reset asserted in cycle T+1 for 1 cycle -> no rsp0_valid in T+2 or T+3; rq0_ready=0 during reset.
- rq0 read 0x0003 followed immediately by rq0 read 0x0004 -> rsp0_valid high for 2 consecutive cycles with mem[3] then mem[4].
